hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 128 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select, load-use / scoreboard stall, long-latency tracker.
// Define STALL_CNT_EN to add the saturating stall_cycles counter output.
module hazard_fwd_unit #(
  parameter int NUM_RD   = 2,
  parameter int NUM_SRC  = 2,
  parameter int SB_DEPTH = 4,
  parameter int LAT_W    = 4,
  parameter int SEL_W    = $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*5-1:0]      ex_rs,
  input  logic [NUM_RD*5-1:0]      id_rs,
  input  logic [NUM_RD-1:0]        id_rs_used,
  input  logic [NUM_SRC*5-1:0]     src_rd,
  input  logic [NUM_SRC-1:0]       src_regwrite,
  input  logic [NUM_SRC-1:0]       src_ready,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic                     stall,
  output logic                     issue_ready
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  logic [SB_DEPTH-1:0] sb_valid;
  logic [4:0]          sb_rd  [SB_DEPTH];
  logic [LAT_W-1:0]    sb_cnt [SB_DEPTH];

  logic [SB_DEPTH-1:0] alloc_oh;
  logic                alloc_found;
  logic                issue_acc;
  logic                do_alloc;
  logic [LAT_W-1:0]    lat_eff;
  logic                load_use;
  logic                sb_hit;
  logic                byp_hit;

  // Youngest matching stage wins: scan oldest first, later hits overwrite.
  always_comb begin
    fwd_sel = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        if (src_regwrite[k] &&
            ex_rs[p*5 +: 5] != 5'd0 &&
            src_rd[k*5 +: 5] == ex_rs[p*5 +: 5])
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  assign issue_ready = ~&sb_valid;
  assign issue_acc   = issue_valid & issue_ready;
  assign do_alloc    = issue_acc & (issue_rd != 5'd0);
  assign lat_eff     = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (!sb_valid[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    sb_hit   = 1'b0;
    byp_hit  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (id_rs_used[p] && id_rs[p*5 +: 5] != 5'd0) begin
        if (src_regwrite[0] && !src_ready[0] &&
            src_rd[4:0] == id_rs[p*5 +: 5])
          load_use = 1'b1;
        if (issue_acc && issue_rd == id_rs[p*5 +: 5])
          byp_hit = 1'b1;
        for (int i = 0; i < SB_DEPTH; i++) begin
          if (sb_valid[i] && sb_rd[i] == id_rs[p*5 +: 5])
            sb_hit = 1'b1;
        end
      end
    end
  end

  assign stall = load_use | sb_hit | byp_hit;

  // A slot freeing this cycle is still valid, so it is never reallocated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_rd[i]  <= 5'd0;
        sb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (sb_valid[i]) begin
          if (sb_cnt[i] == LAT_W'(1)) begin
            sb_valid[i] <= 1'b0;
            sb_cnt[i]   <= '0;
          end else begin
            sb_cnt[i] <= sb_cnt[i] - LAT_W'(1);
          end
        end else if (do_alloc && alloc_oh[i]) begin
          sb_valid[i] <= 1'b1;
          sb_rd[i]    <= issue_rd;
          sb_cnt[i]   <= lat_eff;
        end
      end
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= 32'd0;
    else if (stall && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: vector table plus multi-cycle scoreboard sequences.
// Expected values are queued at drive time and compared at the falling edge.
module tb_hazard_fwd_unit;

  localparam int NUM_RD   = 2;
  localparam int NUM_SRC  = 2;
  localparam int SB_DEPTH = 4;
  localparam int LAT_W    = 4;
  localparam int SEL_W    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [NUM_RD*5-1:0]     ex_rs;
  logic [NUM_RD*5-1:0]     id_rs;
  logic [NUM_RD-1:0]       id_rs_used;
  logic [NUM_SRC*5-1:0]    src_rd;
  logic [NUM_SRC-1:0]      src_regwrite;
  logic [NUM_SRC-1:0]      src_ready;
  logic                    issue_valid;
  logic [4:0]              issue_rd;
  logic [LAT_W-1:0]        issue_lat;
  logic [NUM_RD*SEL_W-1:0] fwd_sel;
  logic                    stall;
  logic                    issue_ready;
`ifdef STALL_CNT_EN
  logic [31:0]             stall_cycles;
`endif

  hazard_fwd_unit #(
    .NUM_RD(NUM_RD), .NUM_SRC(NUM_SRC),
    .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_rs(ex_rs), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .src_rd(src_rd), .src_regwrite(src_regwrite),
    .src_ready(src_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_lat(issue_lat),
    .fwd_sel(fwd_sel), .stall(stall), .issue_ready(issue_ready)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    string    nm;
    logic     chk_fwd;
    logic [3:0] fwd;
    logic     stl;
    logic     rdy;
  } exp_t;

  typedef struct {
    logic [9:0] ex;
    logic [9:0] id;
    logic [1:0] used;
    logic [9:0] srd;
    logic [1:0] rw;
    logic [1:0] rdy;
    logic [3:0] fwd;
    logic       stl;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned exp_stalls = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(string nm, logic cf, logic [3:0] f,
                      logic s, logic r);
    exp_t e;
    e.nm = nm; e.chk_fwd = cf; e.fwd = f; e.stl = s; e.rdy = r;
    sbq.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue_empty actual=0 expected=1");
    end else begin
      e = sbq.pop_front();
      if (e.chk_fwd) chk({e.nm, ".fwd"}, 32'(fwd_sel), 32'(e.fwd));
      chk({e.nm, ".stall"}, 32'(stall), 32'(e.stl));
      chk({e.nm, ".ready"}, 32'(issue_ready), 32'(e.rdy));
`ifdef STALL_CNT_EN
      chk({e.nm, ".cnt"}, stall_cycles, exp_stalls);
`endif
      if (e.stl) exp_stalls++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(string nm, logic s, logic r);
    push(nm, 1'b0, 4'd0, s, r);
    sample();
  endtask

  task automatic clear_in();
    ex_rs = '0; id_rs = '0; id_rs_used = '0;
    src_rd = '0; src_regwrite = '0; src_ready = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
  endtask

  task automatic idle(int n);
    clear_in();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(logic [4:0] rd, logic [LAT_W-1:0] lat);
    issue_valid = 1'b1; issue_rd = rd; issue_lat = lat;
  endtask

  function automatic vec_t mk(logic [9:0] ex, logic [9:0] id,
                              logic [1:0] used, logic [9:0] srd,
                              logic [1:0] rw, logic [1:0] rdy,
                              logic [3:0] f, logic s);
    vec_t v;
    v.ex = ex; v.id = id; v.used = used; v.srd = srd;
    v.rw = rw; v.rdy = rdy; v.fwd = f; v.stl = s;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk({5'd0,5'd5}, 10'd0, 2'b00, {5'd5,5'd5},
                2'b11, 2'b11, 4'b0001, 1'b0);
    vt[1]  = mk({5'd0,5'd5}, 10'd0, 2'b00, {5'd5,5'd5},
                2'b10, 2'b11, 4'b0010, 1'b0);
    vt[2]  = mk({5'd0,5'd5}, 10'd0, 2'b00, {5'd5,5'd5},
                2'b00, 2'b11, 4'b0000, 1'b0);
    vt[3]  = mk(10'd0, 10'd0, 2'b00, 10'd0,
                2'b11, 2'b11, 4'b0000, 1'b0);
    vt[4]  = mk({5'd4,5'd3}, 10'd0, 2'b00, {5'd3,5'd4},
                2'b11, 2'b11, 4'b0110, 1'b0);
    vt[5]  = mk(10'd0, {5'd7,5'd0}, 2'b10, {5'd0,5'd7},
                2'b01, 2'b00, 4'b0000, 1'b1);
    vt[6]  = mk(10'd0, {5'd7,5'd0}, 2'b10, {5'd0,5'd7},
                2'b01, 2'b01, 4'b0000, 1'b0);
    vt[7]  = mk(10'd0, 10'd0, 2'b10, 10'd0,
                2'b01, 2'b00, 4'b0000, 1'b0);
    vt[8]  = mk(10'd0, {5'd7,5'd0}, 2'b00, {5'd0,5'd7},
                2'b01, 2'b00, 4'b0000, 1'b0);
    vt[9]  = mk(10'd0, {5'd7,5'd0}, 2'b10, {5'd7,5'd3},
                2'b11, 2'b00, 4'b0000, 1'b0);
    vt[10] = mk(10'd0, {5'd0,5'd7}, 2'b01, {5'd0,5'd7},
                2'b00, 2'b00, 4'b0000, 1'b0);
    vt[11] = mk({5'd9,5'd0}, 10'd0, 2'b00, {5'd0,5'd9},
                2'b01, 2'b00, 4'b0100, 1'b0);
    vt[12] = mk({5'd6,5'd6}, {5'd6,5'd0}, 2'b10, {5'd6,5'd2},
                2'b11, 2'b00, 4'b1010, 1'b0);

    clear_in();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_stalls = 0;
    push("reset", 1'b1, 4'd0, 1'b0, 1'b1);
    sample();

    foreach (vt[i]) begin
      ex_rs = vt[i].ex; id_rs = vt[i].id; id_rs_used = vt[i].used;
      src_rd = vt[i].srd; src_regwrite = vt[i].rw;
      src_ready = vt[i].rdy;
      push($sformatf("vec%0d", i), 1'b1, vt[i].fwd, vt[i].stl, 1'b1);
      sample();
    end

    // rd=9 lat=3: stalls issue cycle plus three more
    clear_in();
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    issue(5'd9, 4'd3);
    step("lat3_c0", 1'b1, 1'b1);
    issue_valid = 1'b0;
    for (int i = 1; i <= 3; i++) step($sformatf("lat3_c%0d", i), 1'b1, 1'b1);
    step("lat3_c4", 1'b0, 1'b1);

    // zero latency occupies one cycle
    id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01;
    issue(5'd10, 4'd0);
    step("lat0_c0", 1'b1, 1'b1);
    issue_valid = 1'b0;
    step("lat0_c1", 1'b1, 1'b1);
    step("lat0_c2", 1'b0, 1'b1);

    // rd=0 issues never allocate
    clear_in();
    for (int i = 0; i < 4; i++) begin
      issue(5'd0, 4'd8);
      step($sformatf("rd0_c%0d", i), 1'b0, 1'b1);
    end
    issue_valid = 1'b0;
    step("rd0_after", 1'b0, 1'b1);

    // fill, drop while full, no reuse of freeing slot
    clear_in();
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 4'd8);
      step($sformatf("fill_c%0d", i), 1'b0, 1'b1);
    end
    issue(5'd5, 4'd1);
    id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
    step("full_c4", 1'b0, 1'b0);
    issue_valid = 1'b0;
    for (int i = 5; i <= 7; i++) step($sformatf("full_c%0d", i), 1'b0, 1'b0);
    issue(5'd12, 4'd8);
    id_rs = {5'd0, 5'd12};
    step("full_c8", 1'b0, 1'b0);
    issue_valid = 1'b0;
    id_rs = {5'd2, 5'd12}; id_rs_used = 2'b11;
    step("free_c9", 1'b1, 1'b1);
    step("free_c10", 1'b0, 1'b1);
    idle(4);

    // duplicate rd: stall until the later entry frees
    id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    issue(5'd9, 4'd2);
    step("dup_c0", 1'b1, 1'b1);
    issue(5'd9, 4'd5);
    step("dup_c1", 1'b1, 1'b1);
    issue_valid = 1'b0;
    for (int i = 2; i <= 6; i++) step($sformatf("dup_c%0d", i), 1'b1, 1'b1);
    step("dup_c7", 1'b0, 1'b1);

    // reset with three pending plus an issue in the reset cycle
    clear_in();
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 1), 4'd8);
      step($sformatf("pre_rst_c%0d", i), 1'b0, 1'b1);
    end
    issue(5'd4, 4'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_stalls = 0;
    issue_valid = 1'b0;
    id_rs = {5'd1, 5'd4}; id_rs_used = 2'b11;
    step("rst_mid", 1'b0, 1'b1);
    id_rs_used = 2'b00;
    for (int i = 0; i < 4; i++) begin
      issue(5'(20 + i), 4'd8);
      step($sformatf("refill_c%0d", i), 1'b0, 1'b1);
    end
    issue_valid = 1'b0;
    step("refill_full", 1'b0, 1'b0);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_leftover actual=%0d expected=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
